// File: rtl/rsa_host_driver.sv
// rsa_host_driver: host-side initiator for the byte-wide RSA core.
// Loads a 96-byte operand stream (message, exponent, modulus, LSB byte first),
// starts the core, waits for completion and streams the 32-byte result out.
// Optional build macro RSA_DRV_TIMEOUT_EN adds a watchdog on the START/BUSY wait
// (parameter TIMEOUT_CYCLES, output err). Without it err is constant 0.
module rsa_host_driver #(
    parameter int NBYTES = 32,
    parameter int RD_LAT = 1
`ifdef RSA_DRV_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 262143
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       rsa_we,
    output logic       rsa_oe,
    output logic       rsa_start,
    output logic [1:0] rsa_reg_sel,
    output logic [4:0] rsa_addr,
    output logic [7:0] rsa_data_i,
    input  logic [7:0] rsa_data_o,
    input  logic       rsa_ready,
    output logic       err
);

    localparam int CW = $clog2(3 * NBYTES + 1);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_N       = CW'(NBYTES);
    localparam logic [CW-1:0] CNT_2N      = CW'(2 * NBYTES);
    localparam logic [CW-1:0] CNT_LAST    = CW'(3 * NBYTES - 1);
    localparam logic [4:0]    ADDR_LAST   = 5'(NBYTES - 1);
    localparam logic [7:0]    LAT_LAST    = 8'(RD_LAT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_GAP    = 3'd2,
        ST_START  = 3'd3,
        ST_BUSY   = 3'd4,
        ST_READ   = 3'd5,
        ST_OUT    = 3'd6,
        ST_FINISH = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      lat_q, lat_d;
    logic            we_q, we_d;
    logic            oe_q, oe_d;
    logic            start_q, start_d;
    logic [1:0]      sel_q, sel_d;
    logic [4:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            err_q, err_d;
`ifdef RSA_DRV_TIMEOUT_EN
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
    logic [31:0]     tmo_q, tmo_d;
`endif

    // Handshake and status flags decode straight from the state register.
    assign in_ready    = (state_q == ST_LOAD);
    assign out_valid   = (state_q == ST_OUT);
    assign out_last    = (state_q == ST_OUT) && (addr_q == ADDR_LAST);
    assign busy        = (state_q != ST_IDLE);
    assign rsa_we      = we_q;
    assign rsa_oe      = oe_q;
    assign rsa_start   = start_q;
    assign rsa_reg_sel = sel_q;
    assign rsa_addr    = addr_q;
    assign rsa_data_i  = wdata_q;
    assign out_data    = out_data_q;
    assign err         = err_q;

    // Next-state and registered-output computation for the whole transaction.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        we_d       = 1'b0;
        oe_d       = oe_q;
        start_d    = start_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;
`ifdef RSA_DRV_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_LOAD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    // One core write per accepted byte; the segment picks reg_sel.
                    we_d    = 1'b1;
                    addr_d  = 5'(cnt_q % CNT_N);
                    wdata_d = in_data;
                    if (cnt_q < CNT_N) begin
                        sel_d = 2'b00;
                    end else if (cnt_q < CNT_2N) begin
                        sel_d = 2'b10;
                    end else begin
                        sel_d = 2'b11;
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_GAP: begin
                // Final write is on the bus now; start follows so they never overlap.
                start_d = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                if (!rsa_ready) begin
                    start_d = 1'b0;
                    state_d = ST_BUSY;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (rsa_ready) begin
                    oe_d    = 1'b1;
                    addr_d  = 5'd0;
                    cnt_d   = CNT_ZERO;
                    lat_d   = 8'd0;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_READ: begin
                // Capture after the core has registered the addressed byte.
                if (lat_q == LAT_LAST) begin
                    out_data_d = rsa_data_o;
                    state_d    = ST_OUT;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (addr_q == ADDR_LAST) begin
                        oe_d    = 1'b0;
                        cnt_d   = CNT_ZERO;
                        state_d = ST_FINISH;
                    end else begin
                        addr_d  = addr_q + 5'd1;
                        lat_d   = 8'd0;
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_FINISH: begin
                // Two cycles with oe low let the core fall back to its write state.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    addr_d  = 5'd0;
                    sel_d   = 2'b00;
                    wdata_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                oe_d    = 1'b0;
                start_d = 1'b0;
            end
        endcase
`ifdef RSA_DRV_TIMEOUT_EN
        if ((state_q == ST_START) || (state_q == ST_BUSY)) begin
            if (tmo_q == TMO_LIMIT) begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                we_d    = 1'b0;
                oe_d    = 1'b0;
                start_d = 1'b0;
                sel_d   = 2'b00;
                addr_d  = 5'd0;
                wdata_d = 8'd0;
                err_d   = 1'b1;
                tmo_d   = 32'd0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end else begin
            tmo_d = 32'd0;
        end
`endif
    end

    // State and output registers; asynchronous reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            lat_q      <= 8'd0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
            start_q    <= 1'b0;
            sel_q      <= 2'b00;
            addr_q     <= 5'd0;
            wdata_q    <= 8'd0;
            out_data_q <= 8'd0;
            err_q      <= 1'b0;
`ifdef RSA_DRV_TIMEOUT_EN
            tmo_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
            start_q    <= start_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
`ifdef RSA_DRV_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_rsa_host_driver.sv
// tb_rsa_host_driver: scoreboard bench for rsa_host_driver with a behavioural
// RSA core (modexp on the low 32 bits of each operand, 20-cycle compute).
module tb_rsa_host_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       rsa_we, rsa_oe, rsa_start;
    logic [1:0] rsa_reg_sel;
    logic [4:0] rsa_addr;
    logic [7:0] rsa_data_i;
    logic [7:0] core_do;
    logic       core_rdy;
    logic       err;

    rsa_host_driver #(
        .NBYTES(32),
        .RD_LAT(1)
`ifdef RSA_DRV_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy),
        .rsa_we(rsa_we), .rsa_oe(rsa_oe), .rsa_start(rsa_start),
        .rsa_reg_sel(rsa_reg_sel), .rsa_addr(rsa_addr), .rsa_data_i(rsa_data_i),
        .rsa_data_o(core_do), .rsa_ready(core_rdy), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    // Free-running cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] modexp(logic [31:0] m, logic [31:0] e, logic [31:0] n);
        logic [63:0] r, b;
        r = 64'd1 % {32'd0, n};
        b = {32'd0, m} % {32'd0, n};
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % {32'd0, n};
            b = (b * b) % {32'd0, n};
        end
        return r[31:0];
    endfunction

    // Behavioural core: operand registers, fixed-latency compute, registered read.
    logic [255:0] c_msg, c_exp, c_mod, c_res;
    int           c_busy;
    bit           core_stuck = 1'b0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rdy <= 1'b1;
            c_busy   <= 0;
            core_do  <= 8'd0;
        end else begin
            if (rsa_we) begin
                case (rsa_reg_sel)
                    2'b00:   c_msg[rsa_addr*8 +: 8] <= rsa_data_i;
                    2'b10:   c_exp[rsa_addr*8 +: 8] <= rsa_data_i;
                    2'b11:   c_mod[rsa_addr*8 +: 8] <= rsa_data_i;
                    default: ;
                endcase
            end
            if (core_stuck) begin
                core_rdy <= 1'b0;
            end else if (rsa_start && core_rdy && c_busy == 0) begin
                core_rdy <= 1'b0;
                c_busy   <= 20;
                c_res    <= {224'd0, modexp(c_msg[31:0], c_exp[31:0], c_mod[31:0])};
            end else if (c_busy > 0) begin
                c_busy <= c_busy - 1;
                if (c_busy == 1) core_rdy <= 1'b1;
            end
            if (rsa_oe) core_do <= c_res[rsa_addr*8 +: 8];
        end
    end

    int checks = 0;
    int errors = 0;
    logic [8:0]  outq[$];
    logic [14:0] wq[$];
    int out_cnt = 0, wr_cnt = 0, start_cnt = 0, err_pulses = 0;
    int unsigned last_hs_cyc = 0, start_cyc = 0, err_cyc = 0, first_acc_cyc = 0;
    bit bp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_loop();
        logic        prev_start = 1'b0;
        int          stall = 0;
        int          fin_left = 0;
        logic [14:0] w;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0;
                fin_left   = 0;
            end else begin
                if (rsa_start && !prev_start) begin
                    start_cnt++;
                    start_cyc = cyc;
                end
                prev_start = rsa_start;
                if (err) begin
                    err_pulses++;
                    err_cyc = cyc;
                end
                if (rsa_we || rsa_start)
                    check_eq("we_start_excl", 32'(rsa_we & rsa_start), 32'd0);
                if (rsa_we) begin
                    wr_cnt++;
                    if (wq.size() == 0) begin
                        check_eq("write_extra", 32'd1, 32'd0);
                    end else begin
                        w = wq.pop_front();
                        check_eq("write", 32'({rsa_reg_sel, rsa_addr, rsa_data_i}), 32'(w));
                    end
                end
                if (out_valid) begin
                    check_eq("oe_hold", 32'(rsa_oe), 32'd1);
                    if (outq.size() == 0) begin
                        check_eq("out_extra", 32'd1, 32'd0);
                    end else begin
                        check_eq("out_data", 32'(out_data), 32'(outq[0][7:0]));
                        check_eq("out_last", 32'(out_last), 32'(outq[0][8]));
                    end
                    if (bp && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                        stall = 0;
                    end
                    if (out_ready) begin
                        if (outq.size() > 0) void'(outq.pop_front());
                        out_cnt++;
                        if (out_last) begin
                            last_hs_cyc = cyc;
                            fin_left    = 2;
                        end
                    end
                end else begin
                    out_ready = bp ? 1'b0 : 1'b1;
                    if (fin_left > 0) begin
                        check_eq("finish_oe", 32'(rsa_oe), 32'd0);
                        check_eq("finish_busy", 32'(busy), 32'd1);
                        fin_left--;
                    end
                end
            end
        end
    endtask

    task automatic send_txn(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                            input int nsend, input bit gaps, input bit push);
        logic [767:0] stream;
        logic [255:0] res;
        logic [7:0]   b;
        logic [1:0]   sel;
        int           bound;
        stream = {224'd0, n, 224'd0, e, 224'd0, m};
        if (push) begin
            res = {224'd0, modexp(m, e, n)};
            for (int k = 0; k < 32; k++) outq.push_back({(k == 31), res[k*8 +: 8]});
        end
        for (int i = 0; i < nsend; i++) begin
            b   = stream[i*8 +: 8];
            sel = (i < 32) ? 2'b00 : ((i < 64) ? 2'b10 : 2'b11);
            wq.push_back({sel, 5'(i % 32), b});
            if (gaps && i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            bound = 0;
            while (!in_ready && bound < 2000) begin
                @(negedge clk);
                bound++;
            end
            if (!in_ready) begin
                check_eq("in_accept_timeout", 32'd0, 32'd1);
                break;
            end
            if (i == 0) first_acc_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int bound = 0;
        while (out_cnt < target && bound < 5000) begin
            @(negedge clk);
            bound++;
        end
        check_eq("out_done", 32'(out_cnt >= target), 32'd1);
    endtask

    task automatic end_txn(input int s0, input int w0, input int nstart, input int nwr);
        repeat (4) @(negedge clk);
        check_eq("txn_writes", 32'(wr_cnt - w0), 32'(nwr));
        check_eq("txn_starts", 32'(start_cnt - s0), 32'(nstart));
        check_eq("txn_outq_empty", 32'(outq.size()), 32'd0);
        check_eq("txn_wq_empty", 32'(wq.size()), 32'd0);
        check_eq("txn_idle", 32'(busy), 32'd0);
    endtask

    int s0, w0, o0;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        fork
            mon_loop();
        join_none
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_rsa", 32'({rsa_we, rsa_oe, rsa_start, rsa_reg_sel, rsa_addr, rsa_data_i}), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Full transaction, 4^13 mod 497 = 0x1BD.
        s0 = start_cnt; w0 = wr_cnt; o0 = out_cnt;
        send_txn(32'd4, 32'd13, 32'd497, 96, 1'b0, 1'b1);
        wait_out(o0 + 32);
        end_txn(s0, w0, 1, 96);

        // Input gaps on every other cycle.
        s0 = start_cnt; w0 = wr_cnt; o0 = out_cnt;
        send_txn(32'h1234, 32'd17, 32'hFFF1, 96, 1'b1, 1'b1);
        wait_out(o0 + 32);
        end_txn(s0, w0, 1, 96);

        // Output backpressure, 5 stall cycles per byte.
        bp = 1'b1;
        s0 = start_cnt; w0 = wr_cnt; o0 = out_cnt;
        send_txn(32'd7, 32'd3, 32'd1000, 96, 1'b0, 1'b1);
        wait_out(o0 + 32);
        bp = 1'b0;
        end_txn(s0, w0, 1, 96);

        // Reset during load after 40 bytes, then a clean transaction.
        s0 = start_cnt; w0 = wr_cnt;
        send_txn(32'd4, 32'd13, 32'd497, 40, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_we", 32'(rsa_we), 32'd0);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_no_start", 32'(start_cnt - s0), 32'd0);
        check_eq("abort_writes", 32'(wr_cnt - w0), 32'd40);
        check_eq("abort_wq_empty", 32'(wq.size()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        s0 = start_cnt; w0 = wr_cnt; o0 = out_cnt;
        send_txn(32'd4, 32'd13, 32'd497, 96, 1'b0, 1'b1);
        wait_out(o0 + 32);
        end_txn(s0, w0, 1, 96);

        // Back-to-back: second load waits for FINISH (2 cycles) plus IDLE.
        s0 = start_cnt; w0 = wr_cnt; o0 = out_cnt;
        send_txn(32'd9, 32'd5, 32'd211, 96, 1'b0, 1'b1);
        send_txn(32'd4, 32'd13, 32'd497, 96, 1'b0, 1'b1);
        check_eq("b2b_gap", first_acc_cyc - last_hs_cyc, 32'd4);
        wait_out(o0 + 64);
        end_txn(s0, w0, 2, 192);

`ifdef RSA_DRV_TIMEOUT_EN
        // Core never finishes: watchdog aborts with a single err pulse.
        core_stuck = 1'b1;
        o0 = out_cnt; s0 = err_pulses;
        send_txn(32'd4, 32'd13, 32'd497, 96, 1'b0, 1'b0);
        for (int k = 0; k < 400 && err_pulses == s0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_eq("tmo_pulses", 32'(err_pulses - s0), 32'd1);
        check_eq("tmo_latency_ok", 32'((err_cyc - start_cyc) >= 95 && (err_cyc - start_cyc) <= 110), 32'd1);
        check_eq("tmo_idle", 32'(busy), 32'd0);
        check_eq("tmo_rsa", 32'({rsa_we, rsa_oe, rsa_start}), 32'd0);
        check_eq("tmo_no_out", 32'(out_cnt - o0), 32'd0);
        wq.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
